match_round_controller: RTL and testbench
=========================================

// Module: match_round_controller
// PURPOSE
//  Round/match sequencer for the fighting game. Drives round_reset into the physics,
//  collision and health stages and gates player controls during countdown and KO.
//  Consumes the KO result and health from health management. Tracks best-of-N scores
//  and the match winner for the menu and 7-seg display. Owns the hold-to-restart timing.
// PARAMETERS
//  TICK_HZ          20  game-tick strobes per second
//  COUNTDOWN_S      3   pre-fight countdown length, seconds
//  KO_TICKS         40  ticks spent in KO freeze before next round
//  HOLD_TICKS       40  consecutive ticks restart/force input must be held
//  RESET_TICKS      2   ticks round_reset stays asserted
//  ROUNDS_TO_WIN    2   round wins needed to take the match
//  ROUND_TIME_S     60  round clock length (ROUND_TIMER_EN only)
// PORTS
//  clk           in   1  system clock; the single clock
//  reset         in   1  synchronous, active-high
//  tick          in   1  1-cycle game-tick strobe; all sequencing advances only on tick=1
//  winner        in   2  KO result: 00 none, 01 P1, 10 P2, 11 double KO
//  health_1      in   9  P1 health
//  health_2      in   9  P2 health
//  restart_btn   in   1  restart request, honoured only in S_MATCH
//  force_btn     in   1  force full reset, honoured in any state
//  round_reset   out  1  reset to physics/collision/health stages
//  controls_en   out  1  1 = player movement/attack inputs pass
//  countdown     out  4  seconds remaining in countdown, 0 otherwise
//  round_num     out  3  current round, 1-based
//  p1_wins       out  2  P1 rounds won
//  p2_wins       out  2  P2 rounds won
//  match_over    out  1  1 in S_MATCH
//  match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid when match_over=1
//  round_time    out  7  seconds left in round (ROUND_TIMER_EN), else tied to 0
// BEHAVIOUR
//  reset -> S_FULLRST. Outputs: round_reset=1, controls_en=0, countdown=0, round_num=1,
//   wins=0, match_over=0, match_winner=0, round_time=ROUND_TIME_S. reset overrides tick.
//  S_FULLRST: scores cleared and round_num=1. round_reset=1 for RESET_TICKS ticks,
//   then -> S_COUNT with countdown=COUNTDOWN_S.
//  S_RNDRST: same as S_FULLRST, but scores and round_num are kept.
//  S_COUNT: countdown decrements every TICK_HZ ticks. On reaching 0 -> S_FIGHT.
//   round_time loads ROUND_TIME_S. controls_en=0.
//  S_FIGHT: controls_en=1. On a tick with winner!=00 -> S_KO and credit the round:
//   01 -> p1_wins+1; 10 -> p2_wins+1; 11 -> both +1.
//  S_KO: controls_en=0, frozen for KO_TICKS ticks. Then:
//   - if either score == ROUNDS_TO_WIN -> S_MATCH, with match_winner =
//     {p2 reached, p1 reached}; both reached gives 11;
//   - otherwise round_num+1 -> S_RNDRST.
//  S_MATCH: match_over=1, controls_en=0. restart_btn held HOLD_TICKS ticks -> S_FULLRST.
//  force_btn held HOLD_TICKS consecutive ticks in any state -> S_FULLRST. This has
//   priority over every other transition on the same tick.
//  Hold counters clear on any tick where the input is 0. They saturate; they do not wrap.
//  Scores saturate at ROUNDS_TO_WIN. round_num saturates at 7.
//  A winner change during S_KO, S_COUNT or S_MATCH is ignored.
//  All outputs are registered. A transition taken on tick n is visible on the cycle after n.
// CONFIGURATION
//  ROUND_TIMER_EN defined:
//   - in S_FIGHT, round_time decrements every TICK_HZ ticks;
//   - at 0 -> S_KO, credited as health_1>health_2 ? P1 : health_2>health_1 ? P2 : both;
//   - a KO and the timeout on the same tick: the KO result wins.
//  ROUND_TIMER_EN undefined: no round clock; round_time=0; health inputs unused.
// STRUCTURE
//  Package match_pkg holds:
//   - state enum: S_FULLRST, S_RNDRST, S_COUNT, S_FIGHT, S_KO, S_MATCH;
//   - winner encodings W_NONE, W_P1, W_P2, W_DRAW.
//  Sub-module hold_detector (param HOLD_TICKS; ports clk, reset, tick, in, held).
//   Instantiated twice: restart_btn and force_btn.
// TESTING
//  1 Release reset, tick every 4 clk: round_reset high 2 ticks; countdown 3,2,1 over 60 ticks;
//    then controls_en=1.
//  2 In FIGHT, winner=01 for 1 tick: p1_wins=1, controls_en=0 for 40 ticks; round_reset pulse;
//    round_num=2.
//  3 Two P1 KOs: match_over=1, match_winner=01. restart held 39 ticks: nothing.
//    Held 40 ticks: full reset, wins=0.
//  4 winner=11 at 1-1: both reach 2, match_winner=11.
//  5 force_btn held 40 ticks during COUNT: return to S_FULLRST. A 20-tick hold, release,
//    then 20 more ticks: no reset.
//  6 ROUND_TIMER_EN, ROUND_TIME_S=2, health 100 vs 50: after 40 FIGHT ticks, p1_wins=1.
//    Equal health: both credited.

Source files
------------

// File: rtl/match_round_controller_pkg.sv
// Shared state and KO-result encodings plus default tuning for the round sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    S_FULLRST,
    S_RNDRST,
    S_COUNT,
    S_FIGHT,
    S_KO,
    S_MATCH
  } state_t;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;
  localparam logic [1:0] W_DRAW = 2'b11;

  localparam int DEF_TICK_HZ       = 20;
  localparam int DEF_COUNTDOWN_S   = 3;
  localparam int DEF_KO_TICKS      = 40;
  localparam int DEF_HOLD_TICKS    = 40;
  localparam int DEF_RESET_TICKS   = 2;
  localparam int DEF_ROUNDS_TO_WIN = 2;
  localparam int DEF_ROUND_TIME_S  = 60;

  function automatic logic [1:0] sat_inc(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/match_round_controller_hold_detector.sv
// Counts consecutive ticks with i_in high; o_held pulses on every tick that completes
// (or extends past) HOLD_TICKS. The counter saturates and clears on any tick with i_in low.
module hold_detector #(
  parameter int HOLD_TICKS = 40
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_in,
  output logic o_held
);

  localparam int CW = $clog2(HOLD_TICKS + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (!i_in)
        r_cnt <= '0;
      else if (r_cnt != CW'(HOLD_TICKS))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_held = i_tick & i_in & (r_cnt >= CW'(HOLD_TICKS - 1));

endmodule

// File: rtl/match_round_controller.sv
// Round/match sequencer: round resets, countdown, fight gating, KO freeze, best-of-N scoring.
// Define ROUND_TIMER_EN to add the per-round clock that ends a fight on health comparison.
module match_round_controller
  import match_pkg::*;
#(
  parameter int TICK_HZ       = DEF_TICK_HZ,
  parameter int COUNTDOWN_S   = DEF_COUNTDOWN_S,
  parameter int KO_TICKS      = DEF_KO_TICKS,
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int RESET_TICKS   = DEF_RESET_TICKS,
  parameter int ROUNDS_TO_WIN = DEF_ROUNDS_TO_WIN,
  parameter int ROUND_TIME_S  = DEF_ROUND_TIME_S
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic [1:0] i_winner,
  input  logic [8:0] i_health_1,
  input  logic [8:0] i_health_2,
  input  logic       i_restart_btn,
  input  logic       i_force_btn,
  output logic       o_round_reset,
  output logic       o_controls_en,
  output logic [3:0] o_countdown,
  output logic [2:0] o_round_num,
  output logic [1:0] o_p1_wins,
  output logic [1:0] o_p2_wins,
  output logic       o_match_over,
  output logic [1:0] o_match_winner,
  output logic [6:0] o_round_time
);

  localparam int CNT_MAX_A = (RESET_TICKS > TICK_HZ) ? RESET_TICKS : TICK_HZ;
  localparam int CNT_MAX   = (CNT_MAX_A > KO_TICKS) ? CNT_MAX_A : KO_TICKS;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam logic [1:0] RTW = 2'(ROUNDS_TO_WIN);
`ifdef ROUND_TIMER_EN
  localparam logic [6:0] RT_LOAD = 7'(ROUND_TIME_S);
`else
  localparam logic [6:0] RT_LOAD = 7'd0;
  logic w_unused_cfg;
  assign w_unused_cfg = ^{i_health_1, i_health_2, 7'(ROUND_TIME_S)};
`endif

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    r_countdown, w_countdown;
  logic [2:0]    r_round_num, w_round_num;
  logic [1:0]    r_p1, w_p1, r_p2, w_p2, r_mwin, w_mwin;
  logic [6:0]    r_round_time, w_round_time;
  logic [1:0]    w_credit;
  logic          r_round_reset, r_controls_en, r_match_over;

  // Index 0: restart (only counts while the match is over); index 1: force.
  logic [1:0] w_hold_in, w_held;
  assign w_hold_in[0] = i_restart_btn & (r_state == S_MATCH);
  assign w_hold_in[1] = i_force_btn;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
      hold_detector #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_tick (i_tick),
        .i_in   (w_hold_in[gi]),
        .o_held (w_held[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_countdown  = r_countdown;
    w_round_num  = r_round_num;
    w_p1         = r_p1;
    w_p2         = r_p2;
    w_mwin       = r_mwin;
    w_round_time = r_round_time;
    w_credit     = W_NONE;
    if (i_tick) begin
      if (w_held[1] || w_held[0]) begin
        w_state      = S_FULLRST;
        w_cnt        = '0;
        w_countdown  = 4'd0;
        w_round_num  = 3'd1;
        w_p1         = 2'd0;
        w_p2         = 2'd0;
        w_mwin       = W_NONE;
        w_round_time = RT_LOAD;
      end else begin
        case (r_state)
          S_FULLRST, S_RNDRST: begin
            if (r_cnt == CW'(RESET_TICKS - 1)) begin
              w_state      = S_COUNT;
              w_cnt        = '0;
              w_countdown  = 4'(COUNTDOWN_S);
              w_round_time = RT_LOAD;
            end else begin
              w_cnt = r_cnt + CW'(1);
            end
          end
          S_COUNT: begin
            if (r_cnt == CW'(TICK_HZ - 1)) begin
              w_cnt       = '0;
              w_countdown = r_countdown - 4'd1;
              if (r_countdown == 4'd1)
                w_state = S_FIGHT;
            end else begin
              w_cnt = r_cnt + CW'(1);
            end
          end
          S_FIGHT: begin
            w_credit = i_winner;
`ifdef ROUND_TIMER_EN
            // A real KO on the timeout tick takes precedence over the health decision.
            if (r_cnt == CW'(TICK_HZ - 1)) begin
              w_cnt = '0;
              if (r_round_time != 7'd0)
                w_round_time = r_round_time - 7'd1;
              if (r_round_time == 7'd1 && i_winner == W_NONE)
                w_credit = (i_health_1 > i_health_2) ? W_P1 :
                           (i_health_2 > i_health_1) ? W_P2 : W_DRAW;
            end else begin
              w_cnt = r_cnt + CW'(1);
            end
`endif
            if (w_credit != W_NONE) begin
              w_state = S_KO;
              w_cnt   = '0;
              if (w_credit[0]) w_p1 = sat_inc(r_p1, RTW);
              if (w_credit[1]) w_p2 = sat_inc(r_p2, RTW);
            end
          end
          S_KO: begin
            if (r_cnt == CW'(KO_TICKS - 1)) begin
              w_cnt = '0;
              if (r_p1 == RTW || r_p2 == RTW) begin
                w_state = S_MATCH;
                w_mwin  = {r_p2 == RTW, r_p1 == RTW};
              end else begin
                w_state      = S_RNDRST;
                w_round_time = RT_LOAD;
                if (r_round_num != 3'd7)
                  w_round_num = r_round_num + 3'd1;
              end
            end else begin
              w_cnt = r_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_FULLRST;
      r_cnt         <= '0;
      r_countdown   <= 4'd0;
      r_round_num   <= 3'd1;
      r_p1          <= 2'd0;
      r_p2          <= 2'd0;
      r_mwin        <= W_NONE;
      r_round_time  <= RT_LOAD;
      r_round_reset <= 1'b1;
      r_controls_en <= 1'b0;
      r_match_over  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_countdown   <= w_countdown;
      r_round_num   <= w_round_num;
      r_p1          <= w_p1;
      r_p2          <= w_p2;
      r_mwin        <= w_mwin;
      r_round_time  <= w_round_time;
      r_round_reset <= (w_state == S_FULLRST) || (w_state == S_RNDRST);
      r_controls_en <= (w_state == S_FIGHT);
      r_match_over  <= (w_state == S_MATCH);
    end
  end

  assign o_round_reset  = r_round_reset;
  assign o_controls_en  = r_controls_en;
  assign o_countdown    = r_countdown;
  assign o_round_num    = r_round_num;
  assign o_p1_wins      = r_p1;
  assign o_p2_wins      = r_p2;
  assign o_match_over   = r_match_over;
  assign o_match_winner = r_mwin;
  assign o_round_time   = r_round_time;

endmodule

// File: tb/tb_match_round_controller.sv
// Scoreboard bench for match_round_controller: a phase/elapsed-tick model predicts outputs
// for every tick and reset cycle; a monitor compares them the cycle after.
module tb_match_round_controller;

  localparam int TZ   = 20;
  localparam int CDS  = 3;
  localparam int KOT  = 40;
  localparam int HOLD = 40;
  localparam int RSTT = 2;
  localparam int RTW  = 2;
`ifdef ROUND_TIMER_EN
  localparam int RT    = 2;
  localparam bit TIMER = 1'b1;
`else
  localparam int RT    = 60;
  localparam bit TIMER = 1'b0;
`endif

  localparam int PH_RESET = 0;
  localparam int PH_COUNT = 1;
  localparam int PH_FIGHT = 2;
  localparam int PH_KO    = 3;
  localparam int PH_OVER  = 4;

  typedef struct packed {
    logic       rr;
    logic       ce;
    logic [3:0] cd;
    logic [2:0] rn;
    logic [1:0] p1;
    logic [1:0] p2;
    logic       mo;
    logic [1:0] mw;
    logic [6:0] rt;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0, i_tick = 1'b0, i_restart_btn = 1'b0, i_force_btn = 1'b0;
  logic [1:0] i_winner = 2'd0;
  logic [8:0] i_health_1 = 9'd100, i_health_2 = 9'd50;
  logic       o_round_reset, o_controls_en, o_match_over;
  logic [3:0] o_countdown;
  logic [2:0] o_round_num;
  logic [1:0] o_p1_wins, o_p2_wins, o_match_winner;
  logic [6:0] o_round_time;

  always #5 clk = ~clk;

  match_round_controller #(.ROUND_TIME_S(RT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_tick(i_tick), .i_winner(i_winner),
    .i_health_1(i_health_1), .i_health_2(i_health_2),
    .i_restart_btn(i_restart_btn), .i_force_btn(i_force_btn),
    .o_round_reset(o_round_reset), .o_controls_en(o_controls_en), .o_countdown(o_countdown),
    .o_round_num(o_round_num), .o_p1_wins(o_p1_wins), .o_p2_wins(o_p2_wins),
    .o_match_over(o_match_over), .o_match_winner(o_match_winner), .o_round_time(o_round_time)
  );

  int   n_tests = 0, n_fail = 0, n_tx = 0;
  exp_t sb_q[$];

  // Reference model: phase plus ticks elapsed in it; outputs derived arithmetically.
  int m_phase, m_el, m_round, m_p1, m_p2, m_mw, m_rt_frozen, m_force_run, m_restart_run;

  function automatic exp_t model_out();
    exp_t e;
    e.rr = (m_phase == PH_RESET);
    e.ce = (m_phase == PH_FIGHT);
    e.cd = (m_phase == PH_COUNT) ? 4'(CDS - m_el / TZ) : 4'd0;
    e.rn = 3'(m_round);
    e.p1 = 2'(m_p1);
    e.p2 = 2'(m_p2);
    e.mo = (m_phase == PH_OVER);
    e.mw = 2'(m_mw);
    if (!TIMER)                                     e.rt = 7'd0;
    else if (m_phase == PH_FIGHT)                   e.rt = 7'(RT - m_el / TZ);
    else if (m_phase == PH_KO || m_phase == PH_OVER) e.rt = 7'(m_rt_frozen);
    else                                            e.rt = 7'(RT);
    return e;
  endfunction

  task automatic model_full();
    m_phase = PH_RESET; m_el = 0; m_round = 1; m_p1 = 0; m_p2 = 0; m_mw = 0;
  endtask

  task automatic model_tick(input int win, input int h1, input int h2, input bit rb, input bit fb);
    int c;
    m_restart_run = (rb && m_phase == PH_OVER) ? ((m_restart_run < HOLD) ? m_restart_run + 1 : HOLD) : 0;
    m_force_run   = fb ? ((m_force_run < HOLD) ? m_force_run + 1 : HOLD) : 0;
    if (m_force_run == HOLD || m_restart_run == HOLD) begin
      model_full();
      return;
    end
    m_el++;
    case (m_phase)
      PH_RESET: if (m_el == RSTT) begin m_phase = PH_COUNT; m_el = 0; end
      PH_COUNT: if (m_el == CDS * TZ) begin m_phase = PH_FIGHT; m_el = 0; end
      PH_FIGHT: begin
        c = win;
        if (TIMER && c == 0 && m_el == RT * TZ) c = (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
        if (c != 0) begin
          if (c == 1 || c == 3) m_p1 = (m_p1 < RTW) ? m_p1 + 1 : RTW;
          if (c == 2 || c == 3) m_p2 = (m_p2 < RTW) ? m_p2 + 1 : RTW;
          m_rt_frozen = RT - m_el / TZ;
          m_phase = PH_KO; m_el = 0;
        end
      end
      PH_KO: if (m_el == KOT) begin
        m_el = 0;
        if (m_p1 == RTW || m_p2 == RTW) begin
          m_mw = ((m_p2 == RTW) ? 2 : 0) + ((m_p1 == RTW) ? 1 : 0);
          m_phase = PH_OVER;
        end else begin
          m_round = (m_round < 7) ? m_round + 1 : 7;
          m_phase = PH_RESET;
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_reset = 1'b1;
      i_tick  = 1'($urandom_range(0, 1));
      model_full();
      m_force_run = 0; m_restart_run = 0; m_rt_frozen = RT;
      sb_q.push_back(model_out());
    end
    @(negedge clk);
    i_reset = 1'b0;
    i_tick  = 1'b0;
  endtask

  task automatic step(input logic [1:0] win, input bit rb, input bit fb);
    @(negedge clk);
    i_tick = 1'b1; i_winner = win; i_restart_btn = rb; i_force_btn = fb;
    model_tick(int'(win), int'(i_health_1), int'(i_health_2), rb, fb);
    sb_q.push_back(model_out());
    @(negedge clk);
    // Off-tick noise must be ignored by the design.
    i_tick = 1'b0;
    i_winner = 2'($urandom_range(0, 3));
    i_restart_btn = 1'($urandom_range(0, 1));
    i_force_btn = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
  endtask

  // Winner noise only outside FIGHT, where it must be ignored.
  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++)
      step((m_phase == PH_FIGHT) ? 2'd0 : 2'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  task automatic run_to_fight();
    for (int k = 0; k < 200 && m_phase != PH_FIGHT; k++) run_idle(1);
  endtask

  logic sample_pending = 1'b0;
  always @(posedge clk) sample_pending <= i_tick | i_reset;

  always @(negedge clk) begin
    exp_t e, g;
    if (sample_pending) begin
      n_tests++;
      n_tx++;
      g = '{o_round_reset, o_controls_en, o_countdown, o_round_num, o_p1_wins, o_p2_wins,
            o_match_over, o_match_winner, o_round_time};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx%0d scoreboard: output with no expectation, got %h required an entry", n_tx, g);
      end else begin
        e = sb_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL tx%0d outputs: got rr%0b ce%0b cd%0d rn%0d p1=%0d p2=%0d mo%0b mw%0d rt%0d, required rr%0b ce%0b cd%0d rn%0d p1=%0d p2=%0d mo%0b mw%0d rt%0d",
                   n_tx, g.rr, g.ce, g.cd, g.rn, g.p1, g.p2, g.mo, g.mw, g.rt,
                   e.rr, e.ce, e.cd, e.rn, e.p1, e.p2, e.mo, e.mw, e.rt);
        end else begin
          $display("[TB] tx%0d ok rr%0b ce%0b cd%0d rn%0d p1=%0d p2=%0d mo%0b mw%0d rt%0d",
                   n_tx, g.rr, g.ce, g.cd, g.rn, g.p1, g.p2, g.mo, g.mw, g.rt);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Reset pulse, countdown, first fight and a P1 KO.
    run_idle(RSTT + CDS * TZ);
    step(2'b01, 1'b0, 1'b0);
    run_idle(KOT + RSTT + CDS * TZ);
    step(2'b01, 1'b0, 1'b0);
    run_idle(KOT);
    // Restart: 39 ticks is not enough, a full 40-tick hold resets the match.
    for (int k = 0; k < HOLD - 1; k++) step(2'($urandom_range(0, 3)), 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    for (int k = 0; k < HOLD; k++) step(2'($urandom_range(0, 3)), 1'b1, 1'b0);
    // 1-1 then a double KO finishes as a draw.
    run_to_fight(); step(2'b01, 1'b0, 1'b0);
    run_idle(1); run_to_fight(); step(2'b10, 1'b0, 1'b0);
    run_idle(1); run_to_fight(); step(2'b11, 1'b0, 1'b0);
    run_idle(KOT);
    // Force from the match screen, then during the countdown, then a split hold.
    for (int k = 0; k < HOLD; k++) step(2'd0, 1'b0, 1'b1);
    run_idle(RSTT + 10);
    for (int k = 0; k < HOLD; k++) step(2'd0, 1'b0, 1'b1);
    run_idle(RSTT + 10);
    for (int k = 0; k < HOLD / 2; k++) step(2'd0, 1'b0, 1'b1);
    step(2'd0, 1'b0, 1'b0);
    for (int k = 0; k < HOLD / 2; k++) step(2'd0, 1'b0, 1'b1);
    // Round clock decisions by health (only decisive when the timer is built in).
    i_health_1 = 9'd100; i_health_2 = 9'd50;
    run_to_fight(); run_idle(2 * TZ);
    i_health_1 = 9'd77; i_health_2 = 9'd77;
    run_idle(1); run_to_fight(); run_idle(2 * TZ);
    // Random soak segments.
    for (int s = 0; s < 30; s++) begin
      int mode, len;
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 50);
      i_health_1 = 9'($urandom_range(0, 300));
      i_health_2 = ($urandom_range(0, 3) == 0) ? i_health_1 : 9'($urandom_range(0, 300));
      for (int k = 0; k < len; k++) begin
        case (mode)
          0: run_idle(1);
          1: step(($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0, 1'b0, 1'b0);
          2: step(2'($urandom_range(0, 3)), 1'b0, 1'b1);
          default: step(2'd0, 1'b1, 1'b0);
        endcase
      end
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
